// File: rtl/wb_stage_ld.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_ld
// Description : Writeback pipeline stage. Holds the instruction handed over by
//               MEM, waits for the data-SRAM response on loads, extends
//               sub-word load data, drives the register-file write port, the
//               trace port and a forwarding view for ID, and counts retired
//               instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_ld #(
    parameter int PC_W  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32,
    localparam int BUS_W = PC_W + 1 + AW + 32 + 6
) (
    input  logic             clk,
    input  logic             reset,
    // handoff from MEM
    input  logic             ms_to_ws_valid,
    input  logic [BUS_W-1:0] ms_to_ws_bus,
    output logic             ws_allowin,
    // data-SRAM response
    input  logic             data_ok,
    input  logic [31:0]      data_rdata,
    // register-file write port
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [31:0]      rf_wdata,
    // forwarding / hazard view for ID
    output logic             fwd_valid,
    output logic             fwd_ready,
    output logic [AW-1:0]    fwd_addr,
    output logic [31:0]      fwd_data,
    // retired-instruction counter
    output logic [CNT_W-1:0] retire_cnt,
    // trace / debug port
    output logic [PC_W-1:0]  debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [AW-1:0]    debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
);

    // load-extension opcodes; 5..7 behave as a full-word load
    localparam logic [2:0] c_LD_LW  = 3'd0;
    localparam logic [2:0] c_LD_LB  = 3'd1;
    localparam logic [2:0] c_LD_LBU = 3'd2;
    localparam logic [2:0] c_LD_LH  = 3'd3;
    localparam logic [2:0] c_LD_LHU = 3'd4;

    logic             r_ws_valid;
    logic [BUS_W-1:0] r_stage;
    logic [CNT_W-1:0] r_retire_cnt;

    logic [PC_W-1:0]  w_pc;
    logic             w_rf_we_bit;
    logic [AW-1:0]    w_rf_waddr;
    logic [31:0]      w_result;
    logic             w_ld_req;
    logic [2:0]       w_ld_op;
    logic [1:0]       w_ld_off;

    logic             w_ready_go;
    logic             w_ws_wait;
    logic             w_retire;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic [31:0]      w_wdata;

    // unpack the stage register, MSB to LSB
    assign {w_pc, w_rf_we_bit, w_rf_waddr, w_result, w_ld_req, w_ld_op, w_ld_off} = r_stage;

    // a load is done only when the SRAM answers; anything else is done at once
    assign w_ready_go = ~w_ld_req | data_ok;
    // WAIT: occupied by a load whose data has not arrived yet
    assign w_ws_wait  = r_ws_valid & w_ld_req & ~data_ok;
    assign w_retire   = r_ws_valid & w_ready_go;
    assign ws_allowin = ~w_ws_wait;

    // select the addressed byte/half of the response word and extend it
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = data_rdata;
        case (w_ld_off)
            2'd0:    w_byte = data_rdata[7:0];
            2'd1:    w_byte = data_rdata[15:8];
            2'd2:    w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
        w_half = w_ld_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (w_ld_op)
            c_LD_LW:  w_load_data = data_rdata;
            c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_data = {24'h000000, w_byte};
            c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_LD_LHU: w_load_data = {16'h0000, w_half};
            default:  w_load_data = data_rdata;
        endcase
    end

    assign w_wdata = w_ld_req ? w_load_data : w_result;

    // stage register: take MEM's instruction whenever we can accept, go empty if MEM has none
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_stage    <= '0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid;
            if (ms_to_ws_valid) begin
                r_stage <= ms_to_ws_bus;
            end
        end
    end

    // count every retiring instruction, writing or not; wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign rf_we             = w_retire & w_rf_we_bit;
    assign rf_waddr          = w_rf_waddr;
    assign rf_wdata          = w_wdata;

    assign fwd_valid         = r_ws_valid & w_rf_we_bit & (w_rf_waddr != '0);
    assign fwd_ready         = w_ready_go;
    assign fwd_addr          = w_rf_waddr;
    assign fwd_data          = w_wdata;

    assign retire_cnt        = r_retire_cnt;

    assign debug_wb_pc       = w_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = w_rf_waddr;
    assign debug_wb_rf_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_ld.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_ld
// Description : Scoreboard bench for wb_stage_ld. A driver feeds MEM handoffs
//               and SRAM responses and queues the expected register writes; a
//               monitor on the falling edge pops and compares them. A second
//               instance with a 4-bit counter shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_ld;

    localparam int c_BUS_W = 32 + 1 + 5 + 32 + 6;

    typedef struct {
        logic [31:0] pc;
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] result;
        bit          ld_req;
        logic [2:0]  op;
        logic [1:0]  off;
        logic [31:0] rdata;
        int          wait_c;
        int          idle;
        bit          has_exp;
        logic [31:0] exp_wdata;
    } instr_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wr_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               ms_to_ws_valid;
    logic [c_BUS_W-1:0] ms_to_ws_bus;
    logic               data_ok;
    logic [31:0]        data_rdata;

    logic        ws_allowin, rf_we, fwd_valid, fwd_ready;
    logic [4:0]  rf_waddr, fwd_addr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, fwd_data, debug_wb_rf_wdata, retire_cnt, debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;

    logic        ws_allowin4, rf_we4, fwd_valid4, fwd_ready4;
    logic [4:0]  rf_waddr4, fwd_addr4, debug_wb_rf_wnum4;
    logic [31:0] rf_wdata4, fwd_data4, debug_wb_rf_wdata4, debug_wb_pc4;
    logic [3:0]  retire_cnt4, debug_wb_rf_we4;

    wb_stage_ld #(.PC_W(32), .AW(5), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ws_allowin(ws_allowin),
        .data_ok(data_ok), .data_rdata(data_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    wb_stage_ld #(.PC_W(32), .AW(5), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ws_allowin(ws_allowin4),
        .data_ok(data_ok), .data_rdata(data_rdata),
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .fwd_valid(fwd_valid4), .fwd_ready(fwd_ready4), .fwd_addr(fwd_addr4), .fwd_data(fwd_data4),
        .retire_cnt(retire_cnt4), .debug_wb_pc(debug_wb_pc4), .debug_wb_rf_we(debug_wb_rf_we4),
        .debug_wb_rf_wnum(debug_wb_rf_wnum4), .debug_wb_rf_wdata(debug_wb_rf_wdata4)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    instr_t stim_q[$];
    wr_t    wr_q[$];

    // transaction-level model of what the stage holds
    instr_t cur;
    bit     cur_valid = 1'b0;
    int     cur_wait  = 0;
    instr_t in_t;
    bit     in_valid;
    bit     m_retire, m_allowin, exp_we, exp_fwd_valid;
    int     exp_cnt   = 0;
    int     gap_cnt   = 0;
    bit     force_ok  = 1'b0;
    bit     mon_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // expected write data from the load rules, using plain shifts and arithmetic
    function automatic logic [31:0] ref_wdata(instr_t t);
        logic [31:0] b, h;
        if (!t.ld_req) return t.result;
        b = (t.rdata >> (8 * int'(t.off))) & 32'hFF;
        h = (t.rdata >> (16 * (int'(t.off) / 2))) & 32'hFFFF;
        case (t.op)
            3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return t.rdata;
        endcase
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input bit we, input logic [4:0] waddr,
                                  input logic [31:0] result, input bit ld, input logic [2:0] op,
                                  input logic [1:0] off, input logic [31:0] rdata, input int wt,
                                  input bit has_exp, input logic [31:0] exp_wdata);
        instr_t t;
        t.pc = pc; t.we = we; t.waddr = waddr; t.result = result; t.ld_req = ld; t.op = op;
        t.off = off; t.rdata = rdata; t.wait_c = wt; t.idle = 0;
        t.has_exp = has_exp; t.exp_wdata = exp_wdata;
        return t;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t;
        t.pc = $urandom & 32'hFFFF_FFFC;
        t.we = ($urandom_range(0, 3) != 0);
        t.waddr = 5'($urandom);
        t.result = $urandom;
        t.ld_req = ($urandom_range(0, 1) == 1);
        t.op = 3'($urandom);
        t.off = 2'($urandom);
        t.rdata = $urandom;
        t.wait_c = int'($urandom_range(0, 4));
        t.idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        t.has_exp = 1'b0;
        t.exp_wdata = 32'h0;
        return t;
    endfunction

    // one clock cycle: drive inputs, predict this cycle, then advance the model past the edge
    task automatic cycle();
        instr_t h;
        wr_t    w;
        if (force_ok) begin
            data_ok = 1'b1; data_rdata = $urandom;
        end else if (cur_valid && cur.ld_req) begin
            data_ok    = (cur_wait == 0);
            data_rdata = (cur_wait == 0) ? cur.rdata : $urandom;
        end else begin
            data_ok = ($urandom_range(0, 3) == 0); data_rdata = $urandom;
        end
        m_retire      = cur_valid && (!cur.ld_req || data_ok);
        m_allowin     = !cur_valid || m_retire;
        exp_we        = m_retire && cur.we;
        exp_fwd_valid = cur_valid && cur.we && (cur.waddr != 5'd0);
        in_valid       = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = c_BUS_W'({$urandom, $urandom, $urandom});
        if (stim_q.size() > 0) begin
            if (gap_cnt < stim_q[0].idle) begin
                gap_cnt++;
            end else begin
                h = stim_q[0];
                ms_to_ws_valid = 1'b1;
                ms_to_ws_bus   = {h.pc, h.we, h.waddr, h.result, h.ld_req, h.op, h.off};
                if (m_allowin) begin
                    in_valid = 1'b1;
                    in_t     = h;
                    void'(stim_q.pop_front());
                    gap_cnt  = 0;
                    if (h.we) begin
                        w.pc = h.pc; w.waddr = h.waddr;
                        w.wdata = h.has_exp ? h.exp_wdata : ref_wdata(h);
                        wr_q.push_back(w);
                    end
                end
            end
        end
        mon_en = 1'b1;
        @(posedge clk); #1;
        if (m_retire) exp_cnt++;
        if (m_allowin) begin
            cur_valid = in_valid;
            if (in_valid) begin cur = in_t; cur_wait = in_t.wait_c; end
        end else if (cur_wait > 0) begin
            cur_wait--;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stim_q.size() > 0 || cur_valid) && n < budget) begin
            cycle();
            n++;
        end
        if (stim_q.size() > 0 || cur_valid) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: got %0d cycles expected completion", n);
        end
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
    endtask

    task automatic model_clear();
        cur_valid = 1'b0; cur_wait = 0; exp_cnt = 0; gap_cnt = 0;
        wr_q.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0; reset = 1'b1; ms_to_ws_valid = 1'b0; data_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic check_wr(input string tag, input logic [4:0] waddr, input logic [31:0] wdata,
                            input logic [31:0] fdata, input logic [31:0] pc, input logic [3:0] dwe,
                            input logic [4:0] dnum, input logic [31:0] dwdata, input wr_t e);
        chk({tag, "_pc"},       pc,     e.pc);
        chk({tag, "_waddr"},    waddr,  e.waddr);
        chk({tag, "_wdata"},    wdata,  e.wdata);
        chk({tag, "_fwd_data"}, fdata,  e.wdata);
        chk({tag, "_dbg_we"},   dwe,    4'hF);
        chk({tag, "_dbg_wnum"}, dnum,   e.waddr);
        chk({tag, "_dbg_wdata"}, dwdata, e.wdata);
    endtask

    // monitor: compare handshake/forwarding every cycle and pop the scoreboard on each write
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && !reset) begin
            chk("ws_allowin",  ws_allowin,  m_allowin);
            chk("ws_allowin4", ws_allowin4, m_allowin);
            chk("rf_we",       rf_we,       exp_we);
            chk("rf_we4",      rf_we4,      exp_we);
            chk("fwd_valid",   fwd_valid,   exp_fwd_valid);
            chk("fwd_valid4",  fwd_valid4,  exp_fwd_valid);
            chk("retire_cnt",  retire_cnt,  exp_cnt);
            chk("retire_cnt4", retire_cnt4, exp_cnt % 16);
            if (cur_valid) begin
                chk("fwd_ready",    fwd_ready,    m_retire);
                chk("fwd_ready4",   fwd_ready4,   m_retire);
                chk("debug_wb_pc",  debug_wb_pc,  cur.pc);
                chk("debug_wb_pc4", debug_wb_pc4, cur.pc);
                if (exp_fwd_valid) begin
                    chk("fwd_addr",  fwd_addr,  cur.waddr);
                    chk("fwd_addr4", fwd_addr4, cur.waddr);
                end
            end
            if (rf_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_write: got waddr %0d data 0x%08h expected no write", rf_waddr, rf_wdata);
                end else begin
                    e = wr_q.pop_front();
                    check_wr("main", rf_waddr, rf_wdata, fwd_data, debug_wb_pc, debug_wb_rf_we,
                             debug_wb_rf_wnum, debug_wb_rf_wdata, e);
                    check_wr("cnt4", rf_waddr4, rf_wdata4, fwd_data4, debug_wb_pc4, debug_wb_rf_we4,
                             debug_wb_rf_wnum4, debug_wb_rf_wdata4, e);
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; data_ok = 1'b0; data_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin",   ws_allowin,     1'b1);
        chk("rst_rf_we",     rf_we,          1'b0);
        chk("rst_fwd_valid", fwd_valid,      1'b0);
        chk("rst_dbg_we",    debug_wb_rf_we, 4'h0);
        chk("rst_dbg_pc",    debug_wb_pc,    32'h0);
        chk("rst_cnt",       retire_cnt,     32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();

        // three back-to-back ALU results
        stim_q.push_back(mk(32'h1c000000, 1, 5'd1, 32'hA, 0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0000000A));
        stim_q.push_back(mk(32'h1c000004, 1, 5'd2, 32'hB, 0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0000000B));
        stim_q.push_back(mk(32'h1c000008, 1, 5'd3, 32'hC, 0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0000000C));
        drain(50);
        chk("cnt_after_three", retire_cnt, 32'd3);

        // delayed LB, extension sweep, write to r0
        stim_q.push_back(mk(32'h1c00000c, 1, 5'd4, 32'h0, 1, 3'd1, 2'd2, 32'h12F45678, 3, 1, 32'hFFFFFFF4));
        stim_q.push_back(mk(32'h1c000010, 1, 5'd5, 32'h0, 1, 3'd2, 2'd0, 32'h8001FF7F, 1, 1, 32'h0000007F));
        stim_q.push_back(mk(32'h1c000014, 1, 5'd6, 32'h0, 1, 3'd3, 2'd2, 32'h8001FF7F, 0, 1, 32'hFFFF8001));
        stim_q.push_back(mk(32'h1c000018, 1, 5'd7, 32'h0, 1, 3'd4, 2'd0, 32'h8001FF7F, 2, 1, 32'h0000FF7F));
        stim_q.push_back(mk(32'h1c00001c, 1, 5'd8, 32'h0, 1, 3'd0, 2'd0, 32'h8001FF7F, 0, 1, 32'h8001FF7F));
        stim_q.push_back(mk(32'h1c000020, 1, 5'd9, 32'h0, 1, 3'd6, 2'd1, 32'h8001FF7F, 1, 1, 32'h8001FF7F));
        stim_q.push_back(mk(32'h1c000024, 1, 5'd0, 32'h55, 0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h00000055));
        drain(100);
        chk("cnt_after_directed", retire_cnt, 32'd10);

        // randomized traffic checked against the reference model
        for (int i = 0; i < 300; i++) stim_q.push_back(rnd_instr());
        drain(5000);

        // reset while a load waits, then a stray response
        do_reset();
        stim_q.push_back(mk(32'h1c000100, 1, 5'd10, 32'h0, 1, 3'd1, 2'd0, 32'h12345678, 1000, 0, 32'h0));
        n = 0;
        while (!cur_valid && n < 20) begin cycle(); n++; end
        repeat (3) cycle();
        chk("wait_allowin", ws_allowin, 1'b0);
        mon_en = 1'b0; reset = 1'b1; ms_to_ws_valid = 1'b0; data_ok = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        force_ok = 1'b1;
        cycle();
        force_ok = 1'b0;
        chk("post_rst_cnt",       retire_cnt, 32'd0);
        chk("post_rst_rf_we",     rf_we,      1'b0);
        chk("post_rst_fwd_valid", fwd_valid,  1'b0);
        chk("post_rst_allowin",   ws_allowin, 1'b1);
        chk("post_rst_queue",     32'(wr_q.size()), 32'd0);

        // 17 retires on the 4-bit counter wrap to 1
        do_reset();
        for (int i = 0; i < 17; i++)
            stim_q.push_back(mk(32'h1c000200 + 32'(4 * i), 1, 5'(i + 1), 32'(i), 0, 3'd0, 2'd0, 32'h0, 0, 0, 32'h0));
        drain(100);
        chk("wrap_cnt4", retire_cnt4, 4'd1);
        chk("wrap_cnt",  retire_cnt,  32'd17);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
